huffman_bit_packer: RTL and testbench
=====================================

Name: huffman_bit_packer

Overview:
- Downstream neighbour of the Huffman code/literal merge stage in the JPEG compressor.
- Accepts one MSB-aligned variable-length bit group per clock, up to 27 bits, as {huffman,literal,zeros} with a 5-bit length.
- Concatenates the groups into a continuous bitstream and emits 32-bit MSB-first words.
- On flush: pads the tail to a byte boundary with 1s, as JPEG requires, then emits a final partial word. Byte stuffing (0xFF->0xFF00) is a separate downstream stage.

Parameters:
- none (widths fixed by the merge stage: 27-bit data, 5-bit length, 32-bit output).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  in_bits/in_len valid this cycle; no backpressure.
- in_bits  in  27  code bits, MSB-aligned; bits below in_len are don't-care and are masked internally.
- in_len  in  5  number of valid bits, 1..27; 0 = no-op.
- flush  in  1  one-cycle pulse: end of stream.
- busy  out  1  flush in progress; in_valid and flush are illegal while high.
- out_valid  out  1  out_data valid.
- out_data  out  32  packed bits, first bit at [31].
- out_bytes  out  3  valid bytes in out_data: 4 for full words, 0..4 for the final word.
- out_last  out  1  marks the final word of a stream.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: out_valid=0, out_data=0, out_bytes=0, out_last=0, busy=0. Internally acc=0, cnt=0, state=RUN.
- Stage 1 registers in_valid/in_bits/in_len/flush.
  - Masking: bits of in_bits below (27-in_len) are forced to 0.
  - in_len>27 is illegal; clamp to 27.
- Stage 2 holds a 64-bit accumulator acc (MSB-aligned) and a 7-bit bit counter cnt; cnt<32 holds between cycles.
  - Insert: acc |= masked_bits << (37-cnt); cnt += len.
  - Emit: if the new cnt>=32, out_data=acc[63:32], out_bytes=4, out_valid=1, then acc <<= 32 and cnt -= 32. Insert and emit happen in the same cycle.
  - Maximum transient cnt is 31+27=58, so at most one word is emitted per cycle and no overflow is possible.
- Latency: a group that completes a word at input cycle N produces out_valid at cycle N+2.
- Sustained throughput: one 27-bit group per clock, indefinitely.
- State machine (RUN, PAD, EMIT):
  - RUN: normal packing. A stage-1 flush, including one arriving with an in_valid in the same cycle, is processed after the insert of that cycle's data, then the FSM goes to PAD with busy=1. A word emitted by that insert is output normally in that cycle.
  - PAD (1 cycle): pad = (8 - cnt%8)%8 one-bits written at positions below cnt; cnt += pad. Then go to EMIT.
  - EMIT (1 cycle): out_valid=1, out_last=1, out_data=acc[63:32] (unused low bytes=0), out_bytes=cnt/8 (0..4). Then acc=0, cnt=0, busy=0, back to RUN.
  - Empty stream flush (cnt=0): still emits one word with out_bytes=0 and out_last=1.
  - Byte-aligned tail: pad=0, no 1s added.
- flush arriving while busy: ignored. in_valid while busy: discarded (illegal; the bench flags it).
- rst mid-stream or mid-flush: everything is cleared in the same cycle, the partial word is lost, and out_valid=0 on the next cycle.
- out_valid is a single-cycle pulse per word; out_last=0 except in EMIT.

Decomposition:
- Shared JPEG package (existing compressor constants):
  - HUFF_BITS_W=27, HUFF_LEN_W=5, PACK_W=32.
  - FSM state encoding localparams: RUN=2'd0, PAD=2'd1, EMIT=2'd2.
- One natural sub-module, huffman_bit_insert: the combinational mask+shift (bits, len, cnt -> 64-bit OR term and new cnt). It is reusable by the stuffer, which must realign after inserting 0x00.
- FSM and registers stay in the top module.

Test Plan:
- Eight groups of len 4, bits 4'hA each -> one word 0xAAAAAAAA, out_bytes=4, out_valid 2 cycles after the 8th group; no further output.
- Back-to-back every cycle, len 27, all ones, 32 groups -> 27 words of 0xFFFFFFFF with no gaps beyond the count; final cnt=0.
- 3 bits 3'b101 then flush -> single word 0xBF000000, out_bytes=1, out_last=1, busy high for 2 cycles.
- 16 bits 0x1234 then flush -> pad=0, word 0x12340000, out_bytes=2, out_last=1.
- Flush on an empty stream -> one word with out_bytes=0, out_last=1; flush coincident with in_valid len=8 0x5A -> 0x5A000000, out_bytes=1.
- Reset asserted during PAD -> no EMIT word, busy=0 next cycle; a new stream packs from cnt=0 (8x 4'hA -> 0xAAAAAAAA).

Source files
------------

// File: rtl/huffman_bit_packer_pkg.sv
// huffman_bit_packer_pkg: shared JPEG packer widths and FSM state encoding.
package huffman_bit_packer_pkg;
  localparam int HUFF_BITS_W = 27;
  localparam int HUFF_LEN_W = 5;
  localparam int PACK_W = 32;
  typedef enum logic [1:0] {RUN = 2'd0, PAD = 2'd1, EMIT = 2'd2} state_t;
endpackage

// File: rtl/huffman_bit_insert.sv
// huffman_bit_insert: masks an MSB-aligned bit group and aligns it below cnt in a 64-bit window.
module huffman_bit_insert
  import huffman_bit_packer_pkg::*;
(
  input  logic [HUFF_BITS_W-1:0] i_bits,
  input  logic [HUFF_LEN_W-1:0]  i_len,
  input  logic [6:0]             i_cnt,
  output logic [2*PACK_W-1:0]    o_term,
  output logic [6:0]             o_cnt
);
  logic [HUFF_LEN_W-1:0]  w_len;
  logic [HUFF_BITS_W-1:0] w_masked;
  assign w_len = (i_len > HUFF_LEN_W'(HUFF_BITS_W)) ? HUFF_LEN_W'(HUFF_BITS_W) : i_len;
  assign w_masked = i_bits & ~({HUFF_BITS_W{1'b1}} >> w_len);
  assign o_term = {w_masked, {(2*PACK_W-HUFF_BITS_W){1'b0}}} >> i_cnt;
  assign o_cnt = i_cnt + 7'(w_len);
endmodule

// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer: packs variable-length Huffman groups into 32-bit MSB-first words,
// padding the stream tail with 1s to a byte boundary on flush.
module huffman_bit_packer
  import huffman_bit_packer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [HUFF_BITS_W-1:0] in_bits,
  input  logic [HUFF_LEN_W-1:0]  in_len,
  input  logic                   flush,
  output logic                   busy,
  output logic                   out_valid,
  output logic [PACK_W-1:0]      out_data,
  output logic [2:0]             out_bytes,
  output logic                   out_last
);
  state_t                 r_state;
  logic                   r_v;
  logic                   r_flush;
  logic [HUFF_BITS_W-1:0] r_bits;
  logic [HUFF_LEN_W-1:0]  r_len;
  logic [2*PACK_W-1:0]    r_acc;
  logic [6:0]             r_cnt;
  logic [2:0]             w_pad;
  logic [HUFF_LEN_W-1:0]  w_len;
  logic [HUFF_BITS_W-1:0] w_bits;
  logic [2*PACK_W-1:0]    w_term;
  logic [2*PACK_W-1:0]    w_acc;
  logic [6:0]             w_cnt;
  // Padding reuses the insert path with an all-ones group of length pad.
  assign w_pad = 3'd0 - r_cnt[2:0];
  assign w_len = (r_state == PAD) ? HUFF_LEN_W'(w_pad) : (r_state == RUN && r_v) ? r_len : '0;
  assign w_bits = (r_state == PAD) ? '1 : r_bits;
  assign w_acc = r_acc | w_term;
  huffman_bit_insert u_insert (
    .i_bits (w_bits),
    .i_len  (w_len),
    .i_cnt  (r_cnt),
    .o_term (w_term),
    .o_cnt  (w_cnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_v <= 1'b0;
      r_flush <= 1'b0;
      r_bits <= '0;
      r_len <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      busy <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_bytes <= '0;
      out_last <= 1'b0;
    end else begin
      r_v <= in_valid & ~busy;
      r_flush <= flush & ~busy;
      r_bits <= in_bits;
      r_len <= in_len;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_cnt >= 7'd32) begin
            out_valid <= 1'b1;
            out_data <= w_acc[63:32];
            out_bytes <= 3'd4;
            r_acc <= w_acc << 32;
            r_cnt <= w_cnt - 7'd32;
          end else begin
            r_acc <= w_acc;
            r_cnt <= w_cnt;
          end
          if (r_flush) begin
            r_state <= PAD;
            busy <= 1'b1;
          end
        end
        PAD: begin
          r_acc <= w_acc;
          r_cnt <= w_cnt;
          r_state <= EMIT;
        end
        EMIT: begin
          out_valid <= 1'b1;
          out_last <= 1'b1;
          out_data <= r_acc[63:32];
          out_bytes <= r_cnt[5:3];
          r_acc <= '0;
          r_cnt <= '0;
          busy <= 1'b0;
          r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_huffman_bit_packer.sv
// tb_huffman_bit_packer: random and directed stimulus checked against a bit-queue model of the stream.
module tb_huffman_bit_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [26:0] in_bits = '0;
  logic [4:0]  in_len = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_last;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  b;
    logic        l;
    int          c;
  } exp_t;

  bit   bq[$];
  exp_t eq[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  huffman_bit_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bits   (in_bits),
    .in_len    (in_len),
    .flush     (flush),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Take n bits from the front of the stream as one output word.
  task automatic take_word(input int n, input logic last, input int c);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[31-i] = bq[i];
    for (int i = 0; i < n; i++) void'(bq.pop_front());
    eq.push_back('{d: w, b: 3'(n / 8), l: last, c: c});
  endtask

  task automatic drive(input logic v, input logic [26:0] b, input logic [4:0] l, input logic f);
    int n;
    in_valid = v;
    in_bits = b;
    in_len = l;
    flush = f;
    if (v) begin
      n = (l > 5'd27) ? 27 : int'(l);
      for (int i = 0; i < n; i++) bq.push_back(b[26-i]);
      if (bq.size() >= 32) take_word(32, 1'b0, cyc + 2);
    end
    if (f) begin
      while (bq.size() % 8 != 0) bq.push_back(1'b1);
      take_word(bq.size(), 1'b1, cyc + 4);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    bq.delete();
    eq.delete();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (eq.size() == 0) check("spurious_word", 64'(out_data), 64'hDEAD_0000);
        else begin
          e = eq.pop_front();
          check("word_data", 64'(out_data), 64'(e.d));
          check("word_bytes", 64'(out_bytes), 64'(e.b));
          check("word_last", 64'(out_last), 64'(e.l));
          check("word_cycle", 64'(cyc), 64'(e.c));
        end
      end else if (eq.size() != 0 && eq[0].c <= cyc) begin
        check("missing_word", 64'(0), 64'(1));
        void'(eq.pop_front());
      end
    end
  end

  initial begin
    logic [4:0] l;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_bytes", 64'(out_bytes), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    idle(2);
    repeat (8) drive(1'b1, {4'hA, 23'h0}, 5'd4, 1'b0);
    idle(5);
    repeat (32) drive(1'b1, '1, 5'd27, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    idle(3);
    drive(1'b1, {3'b101, 24'h0}, 5'd3, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    check("busy_before_pad", 64'(busy), 64'(0));
    idle(1);
    check("busy_pad", 64'(busy), 64'(1));
    idle(1);
    check("busy_emit", 64'(busy), 64'(1));
    idle(1);
    check("busy_done", 64'(busy), 64'(0));
    drive(1'b1, {16'h1234, 11'h7FF}, 5'd16, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    idle(3);
    drive(1'b0, '0, '0, 1'b1);
    idle(3);
    drive(1'b1, {8'h5A, 19'h0}, 5'd8, 1'b1);
    idle(3);
    drive(1'b1, {5'h1F, 22'h0}, 5'd5, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    idle(1);
    check("busy_in_pad", 64'(busy), 64'(1));
    do_reset();
    check("reset_pad_busy", 64'(busy), 64'(0));
    check("reset_pad_valid", 64'(out_valid), 64'(0));
    idle(4);
    repeat (8) drive(1'b1, {4'hA, 23'h0}, 5'd4, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    idle(3);
    for (int i = 0; i < 600; i++) begin
      l = 5'($urandom_range(0, 29));
      if ($urandom_range(0, 39) == 0) begin
        drive($urandom_range(0, 1) == 1, 27'($urandom), l, 1'b1);
        idle(3);
      end else drive($urandom_range(0, 3) != 0, 27'($urandom), l, 1'b0);
    end
    drive(1'b0, '0, '0, 1'b1);
    idle(6);
    check("queue_drained", 64'(eq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
